// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
package counter_pkg;

    // Behaviour of a counter when a step would leave 0..MODULUS-1.
    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

endpackage : counter_pkg

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with synchronous load, wrap or saturate boundary
// handling, a terminal-count flag, a one-cycle boundary event pulse and
// sticky overflow/underflow flags.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int        WIDTH   = 4,
    parameter longint    MODULUS = 16,
    parameter cnt_mode_e MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             evt,
    output logic             ovf,
    output logic             unf
);

    // 64-bit limit so WIDTH=32 does not overflow the legality check.
    localparam longint MOD_LIM = 64'sd1 <<< WIDTH;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be in 2..32");
    end
    if (MODULUS < 2 || MODULUS > MOD_LIM) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
    end

    // One extra bit keeps the clamp compare and +1/-1 free of truncation.
    localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO_EXT = '0;

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] ld_ext;
    logic [WIDTH:0] nxt_ext;
    logic           at_top;
    logic           at_bot;
    logic           evt_nxt;
    logic           ovf_set;
    logic           unf_set;

    assign cnt_ext = {1'b0, count};
    assign ld_ext  = {1'b0, load_val};
    assign at_top  = (cnt_ext == MAX_EXT);
    assign at_bot  = (cnt_ext == ZERO_EXT);

    // Terminal count looks at the direction currently requested, not at en.
    assign tc = up ? at_top : at_bot;

    // Next count and boundary detection; load outranks counting.
    always_comb begin
        nxt_ext = cnt_ext;
        evt_nxt = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (load) begin
            nxt_ext = (ld_ext > MAX_EXT) ? MAX_EXT : ld_ext;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    evt_nxt = 1'b1;
                    ovf_set = 1'b1;
                    nxt_ext = (MODE == CNT_SAT) ? MAX_EXT : ZERO_EXT;
                end else begin
                    nxt_ext = cnt_ext + ONE_EXT;
                end
            end else begin
                if (at_bot) begin
                    evt_nxt = 1'b1;
                    unf_set = 1'b1;
                    nxt_ext = (MODE == CNT_SAT) ? ZERO_EXT : MAX_EXT;
                end else begin
                    nxt_ext = cnt_ext - ONE_EXT;
                end
            end
        end
    end

    // Registered count, event pulse and sticky flags; a boundary beats clr_flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            evt   <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= nxt_ext[WIDTH-1:0];
            evt   <= evt_nxt;
            ovf   <= ovf_set | (ovf & ~clr_flags);
            unf   <= unf_set | (unf & ~clr_flags);
        end
    end

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three instances (mod-10 wrap, mod-10 saturate,
// mod-16 wrap) share one stimulus stream and are compared against an
// arithmetic reference model.
module tb_mod_updown_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       clr_flags = 1'b0;

    logic [3:0] c_o [3];
    logic       tc_o [3];
    logic       evt_o [3];
    logic       ovf_o [3];
    logic       unf_o [3];

    int checks = 0;
    int failures = 0;

    // Reference model state, one entry per instance.
    int m_mod [3] = '{10, 10, 16};
    bit m_sat [3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt [3];
    bit m_evt [3];
    bit m_ovf [3];
    bit m_unf [3];

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .MODE(CNT_WRAP)) u_wrap10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .count(c_o[0]), .tc(tc_o[0]), .evt(evt_o[0]),
        .ovf(ovf_o[0]), .unf(unf_o[0]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .MODE(CNT_SAT)) u_sat10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .count(c_o[1]), .tc(tc_o[1]), .evt(evt_o[1]),
        .ovf(ovf_o[1]), .unf(unf_o[1]));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16), .MODE(CNT_WRAP)) u_wrap16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .clr_flags(clr_flags), .count(c_o[2]), .tc(tc_o[2]), .evt(evt_o[2]),
        .ovf(ovf_o[2]), .unf(unf_o[2]));

    // Advance one clock: model computes from the inputs in force, then the
    // edge happens and the model commits; returns 1 time unit after the edge.
    task automatic tick();
        int nc [3];
        bit ne [3];
        bit no [3];
        bit nu [3];
        for (int i = 0; i < 3; i++) begin
            nc[i] = m_cnt[i];
            ne[i] = 1'b0;
            no[i] = m_ovf[i] && !clr_flags;
            nu[i] = m_unf[i] && !clr_flags;
            if (rst) begin
                nc[i] = 0; no[i] = 1'b0; nu[i] = 1'b0;
            end else if (load) begin
                nc[i] = (int'(load_val) < m_mod[i]) ? int'(load_val) : m_mod[i] - 1;
                no[i] = m_ovf[i] && !clr_flags;
                nu[i] = m_unf[i] && !clr_flags;
            end else if (en) begin
                int raw;
                raw = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                if (raw >= m_mod[i] || raw < 0) begin
                    ne[i] = 1'b1;
                    if (up) no[i] = 1'b1; else nu[i] = 1'b1;
                    nc[i] = m_sat[i] ? m_cnt[i] : (raw + m_mod[i]) % m_mod[i];
                end else begin
                    nc[i] = raw;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = nc[i]; m_evt[i] = ne[i]; m_ovf[i] = no[i]; m_unf[i] = nu[i];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7; clr_flags = 1'b0; up = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({c_o[i], evt_o[i], ovf_o[i], unf_o[i]} !== 7'd0) begin
                failures++;
                $display("FAIL reset_state[%0d]: got cnt=%0d evt=%0b ovf=%0b unf=%0b, want all 0",
                         i, c_o[i], evt_o[i], ovf_o[i], unf_o[i]);
            end
            checks++;
            if (tc_o[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_tc_down[%0d]: got %0b want 1", i, tc_o[i]);
            end
        end
        up = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tc_o[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_tc_up[%0d]: got %0b want 0", i, tc_o[i]);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1; load = 1'b0; clr_flags = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (c_o[0] !== 4'((i + 1) % 10) || evt_o[0] !== (i == 9)) begin
                failures++;
                $display("FAIL count_up step %0d: got cnt=%0d evt=%0b want cnt=%0d evt=%0b",
                         i, c_o[0], evt_o[0], (i + 1) % 10, (i == 9));
            end
            checks++;
            if (tc_o[0] !== (c_o[0] == 4'd9)) begin
                failures++;
                $display("FAIL count_up_tc step %0d: got %0b at cnt=%0d", i, tc_o[0], c_o[0]);
            end
        end
        checks++;
        if (ovf_o[0] !== 1'b1 || unf_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL count_up_flags: got ovf=%0b unf=%0b want ovf=1 unf=0", ovf_o[0], unf_o[0]);
        end
    endtask

    task automatic test_count_down();
        int exp_c [3] = '{9, 8, 7};
        load = 1'b1; load_val = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0; #1;
        checks++;
        if (tc_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL count_down_tc0: got %0b want 1", tc_o[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (c_o[0] !== 4'(exp_c[i]) || evt_o[0] !== (i == 0)) begin
                failures++;
                $display("FAIL count_down step %0d: got cnt=%0d evt=%0b want cnt=%0d evt=%0b",
                         i, c_o[0], evt_o[0], exp_c[i], (i == 0));
            end
        end
        checks++;
        if (unf_o[0] !== 1'b1 || ovf_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL count_down_flags: got unf=%0b ovf=%0b want unf=1 ovf=1", unf_o[0], ovf_o[0]);
        end
    endtask

    task automatic test_saturate();
        int exp_c [4] = '{8, 9, 9, 9};
        bit exp_e [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        en = 1'b0; clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++;
        if (ovf_o[1] !== 1'b0 || unf_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear: got ovf=%0b unf=%0b want 0 0", ovf_o[1], unf_o[1]);
        end
        load = 1'b1; load_val = 4'd8; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            load = 1'b0;
            checks++;
            if (c_o[1] !== 4'(exp_c[i]) || evt_o[1] !== exp_e[i]) begin
                failures++;
                $display("FAIL saturate step %0d: got cnt=%0d evt=%0b want cnt=%0d evt=%0b",
                         i, c_o[1], evt_o[1], exp_c[i], exp_e[i]);
            end
        end
        checks++;
        if (ovf_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL saturate_ovf: got %0b want 1", ovf_o[1]);
        end
    endtask

    task automatic test_load_clamp();
        load = 1'b1; load_val = 4'd14; en = 1'b1; up = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (c_o[0] !== 4'd9 || evt_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_clamp: got cnt=%0d evt=%0b want cnt=9 evt=0", c_o[0], evt_o[0]);
        end
        clr_flags = 1'b1;
        tick();
        checks++;
        if (ovf_o[0] !== 1'b1 || c_o[0] !== 4'd0 || evt_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_boundary: got ovf=%0b cnt=%0d evt=%0b want ovf=1 cnt=0 evt=1",
                     ovf_o[0], c_o[0], evt_o[0]);
        end
        en = 1'b0;
        tick();
        clr_flags = 1'b0;
        checks++;
        if (ovf_o[0] !== 1'b0 || unf_o[0] !== 1'b0 || evt_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_only: got ovf=%0b unf=%0b evt=%0b want 0 0 0", ovf_o[0], unf_o[0], evt_o[0]);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_val = 4'd5; en = 1'b0;
        tick();
        checks++;
        if (c_o[0] !== 4'd5) begin
            failures++;
            $display("FAIL mid_preload: got %0d want 5", c_o[0]);
        end
        rst = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (c_o[0] !== 4'd0 || evt_o[0] !== 1'b0 || ovf_o[0] !== 1'b0 || unf_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got cnt=%0d evt=%0b ovf=%0b unf=%0b want all 0",
                     c_o[0], evt_o[0], ovf_o[0], unf_o[0]);
        end
        rst = 1'b0; load = 1'b0;
        tick();
        checks++;
        if (c_o[0] !== 4'd1) begin
            failures++;
            $display("FAIL reset_resume: got %0d want 1", c_o[0]);
        end
    endtask

    task automatic test_mod16_down();
        int n_evt = 0;
        rst = 1'b1; en = 1'b0;
        tick(); tick();
        rst = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (evt_o[2]) n_evt++;
            checks++;
            if (c_o[2] !== 4'((16 - ((i + 1) % 16)) % 16) || evt_o[2] !== (i % 16 == 0)) begin
                failures++;
                $display("FAIL mod16_down step %0d: got cnt=%0d evt=%0b want cnt=%0d evt=%0b",
                         i, c_o[2], evt_o[2], (16 - ((i + 1) % 16)) % 16, (i % 16 == 0));
            end
        end
        checks++;
        if (n_evt != 2 || unf_o[2] !== 1'b1 || ovf_o[2] !== 1'b0) begin
            failures++;
            $display("FAIL mod16_summary: got evts=%0d unf=%0b ovf=%0b want 2 1 0", n_evt, unf_o[2], ovf_o[2]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom % 32) == 0;
            load      = ($urandom % 8) == 0;
            en        = ($urandom % 4) != 0;
            up        = ($urandom % 3) != 0;
            load_val  = 4'($urandom);
            clr_flags = ($urandom % 10) == 0;
            #1;
            for (int i = 0; i < 3; i++) begin
                bit exp_tc;
                exp_tc = up ? (m_cnt[i] == m_mod[i] - 1) : (m_cnt[i] == 0);
                checks++;
                if (tc_o[i] !== exp_tc) begin
                    failures++;
                    $display("FAIL rand_tc[%0d] iter %0d: got %0b want %0b", i, n, tc_o[i], exp_tc);
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (c_o[i] !== 4'(m_cnt[i]) || evt_o[i] !== m_evt[i] ||
                    ovf_o[i] !== m_ovf[i] || unf_o[i] !== m_unf[i]) begin
                    failures++;
                    $display("FAIL rand_state[%0d] iter %0d: got cnt=%0d evt=%0b ovf=%0b unf=%0b want cnt=%0d evt=%0b ovf=%0b unf=%0b",
                             i, n, c_o[i], evt_o[i], ovf_o[i], unf_o[i],
                             m_cnt[i], m_evt[i], m_ovf[i], m_unf[i]);
                end
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0; clr_flags = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_evt[i] = 1'b0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
        end
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_clamp();
        test_reset_mid();
        test_mod16_down();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_updown_counter
